// File: rtl/mac_pkg.sv
// mac_pkg: shared constants and FSM state type for the MAC controller.
//   WI      - operand width of one MAC lane
//   N       - lanes per MAC chunk
//   MW      - MAC result width (2*WI + clog2(N) + 6)
//   MAC_LAT - cycles from MAC valid-in to MAC valid-out
//   ACC_W   - dot-product result width
package mac_pkg;

    localparam int unsigned WI      = 8;
    localparam int unsigned N       = 16;
    localparam int unsigned MW      = 2 * WI + $clog2(N) + 6;
    localparam int unsigned MAC_LAT = 9;
    localparam int unsigned ACC_W   = 32;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StDrain,
        StOut
    } state_e;

endpackage

// File: rtl/mac_sat_acc.sv
// mac_sat_acc: signed saturating accumulator with a sticky saturation flag.
// Ports:
//   clk_i, rst_ni - clock, asynchronous active-low reset
//   clr_i         - clear accumulator and sticky flag
//   en_i          - add add_i (sign-extended) into the accumulator this cycle
//   add_i         - signed MW-bit addend
//   acc_o         - signed ACC_W-bit accumulator value
//   sat_o         - set once any addition clamped; cleared by clr_i
module mac_sat_acc #(
    parameter int unsigned MW    = 26,
    parameter int unsigned ACC_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [MW-1:0]    add_i,
    output logic [ACC_W-1:0] acc_o,
    output logic             sat_o
);

    localparam logic [ACC_W-1:0] MaxVal = {1'b0, {(ACC_W - 1){1'b1}}};
    localparam logic [ACC_W-1:0] MinVal = {1'b1, {(ACC_W - 1){1'b0}}};

    logic [ACC_W-1:0] acc_q, acc_d;
    logic             sat_q;
    logic [ACC_W:0]   sum;
    logic             ovf;

    // One guard bit: overflow shows up as the top two sum bits disagreeing.
    always_comb begin
        sum   = {acc_q[ACC_W-1], acc_q} + {{(ACC_W + 1 - MW){add_i[MW-1]}}, add_i};
        ovf   = sum[ACC_W] ^ sum[ACC_W-1];
        acc_d = sum[ACC_W-1:0];
        if (ovf) begin
            acc_d = sum[ACC_W] ? MinVal : MaxVal;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q <= '0;
            sat_q <= 1'b0;
        end else if (clr_i) begin
            acc_q <= '0;
            sat_q <= 1'b0;
        end else if (en_i) begin
            acc_q <= acc_d;
            sat_q <= sat_q | ovf;
        end
    end

    assign acc_o = acc_q;
    assign sat_o = sat_q;

endmodule

// File: rtl/mac_ctrl.sv
// mac_ctrl: sequences one dot-product command through a pipelined MAC.
// Accepts (len, wbase, dbase), streams len buffer reads without bubbles,
// accumulates the returned MAC results with saturation and presents the sum.
// Ports:
//   clk, rstn                          - clock, asynchronous active-low reset
//   cmd_vld_i/cmd_rdy_o                - command handshake (ready only in idle)
//   cmd_len_i, cmd_wbase_i, cmd_dbase_i - chunk count and start addresses
//   buf_rd_o, buf_waddr_o, buf_daddr_o - buffer read strobe and addresses
//   mac_vld_o                          - MAC valid-in (read strobe delayed 1 cycle)
//   mac_vld_i, mac_acc_i               - MAC valid-out and signed result
//   res_vld_o/res_rdy_i                - result handshake
//   res_data_o, res_sat_o              - signed result and saturation flag
//   busy_o                             - high whenever not idle
module mac_ctrl #(
    parameter int unsigned WI      = mac_pkg::WI,
    parameter int unsigned N       = mac_pkg::N,
    parameter int unsigned MW      = 2 * WI + $clog2(N) + 6,
    parameter int unsigned MAC_LAT = mac_pkg::MAC_LAT,
    parameter int unsigned AW      = 10,
    parameter int unsigned LW      = 8,
    parameter int unsigned ACC_W   = mac_pkg::ACC_W
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             cmd_vld_i,
    output logic             cmd_rdy_o,
    input  logic [LW-1:0]    cmd_len_i,
    input  logic [AW-1:0]    cmd_wbase_i,
    input  logic [AW-1:0]    cmd_dbase_i,
    output logic             buf_rd_o,
    output logic [AW-1:0]    buf_waddr_o,
    output logic [AW-1:0]    buf_daddr_o,
    output logic             mac_vld_o,
    input  logic             mac_vld_i,
    input  logic [MW-1:0]    mac_acc_i,
    output logic             res_vld_o,
    input  logic             res_rdy_i,
    output logic [ACC_W-1:0] res_data_o,
    output logic             res_sat_o,
    output logic             busy_o
);
    import mac_pkg::*;

    if (MW > ACC_W) begin : g_bad_width
        $error("mac_ctrl: MW must not exceed ACC_W");
    end
    if (MAC_LAT < 1) begin : g_bad_lat
        $error("mac_ctrl: MAC_LAT must be at least 1");
    end

    state_e        state_q;
    logic [LW-1:0] len_q, iss_cnt_q, rcv_cnt_q;
    logic [AW-1:0] waddr_q, daddr_q;
    logic          cmd_rdy_q, buf_rd_q, mac_vld_q, res_vld_q, busy_q;

    logic          accept, count_en, last_rd;
    logic [LW-1:0] rcv_next;

    always_comb begin
        accept   = cmd_vld_i & cmd_rdy_q;
        // Results are only meaningful while a command is in flight.
        count_en = mac_vld_i & ((state_q == StIssue) | (state_q == StDrain));
        rcv_next = rcv_cnt_q + LW'(count_en);
        last_rd  = (iss_cnt_q + LW'(1)) == len_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= StIdle;
            len_q     <= '0;
            iss_cnt_q <= '0;
            rcv_cnt_q <= '0;
            waddr_q   <= '0;
            daddr_q   <= '0;
            cmd_rdy_q <= 1'b0;
            buf_rd_q  <= 1'b0;
            mac_vld_q <= 1'b0;
            res_vld_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            mac_vld_q <= buf_rd_q;
            rcv_cnt_q <= rcv_next;
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        len_q     <= cmd_len_i;
                        waddr_q   <= cmd_wbase_i;
                        daddr_q   <= cmd_dbase_i;
                        iss_cnt_q <= '0;
                        rcv_cnt_q <= '0;
                        cmd_rdy_q <= 1'b0;
                        busy_q    <= 1'b1;
                        if (cmd_len_i != '0) begin
                            state_q  <= StIssue;
                            buf_rd_q <= 1'b1;
                        end else begin
                            state_q   <= StOut;
                            res_vld_q <= 1'b1;
                        end
                    end else begin
                        // Ready rises one cycle after reset release.
                        cmd_rdy_q <= 1'b1;
                    end
                end
                StIssue: begin
                    iss_cnt_q <= iss_cnt_q + LW'(1);
                    waddr_q   <= waddr_q + AW'(1);
                    daddr_q   <= daddr_q + AW'(1);
                    if (last_rd) begin
                        buf_rd_q <= 1'b0;
                        state_q  <= StDrain;
                    end
                end
                StDrain: begin
                    // Leave on the edge that absorbs the final result.
                    if (rcv_next == len_q) begin
                        state_q   <= StOut;
                        res_vld_q <= 1'b1;
                    end
                end
                StOut: begin
                    if (res_rdy_i) begin
                        state_q   <= StIdle;
                        res_vld_q <= 1'b0;
                        cmd_rdy_q <= 1'b1;
                        busy_q    <= 1'b0;
                    end
                end
            endcase
        end
    end

    mac_sat_acc #(
        .MW    (MW),
        .ACC_W (ACC_W)
    ) u_acc (
        .clk_i  (clk),
        .rst_ni (rstn),
        .clr_i  (accept),
        .en_i   (count_en),
        .add_i  (mac_acc_i),
        .acc_o  (res_data_o),
        .sat_o  (res_sat_o)
    );

    assign cmd_rdy_o   = cmd_rdy_q;
    assign buf_rd_o    = buf_rd_q;
    assign buf_waddr_o = waddr_q;
    assign buf_daddr_o = daddr_q;
    assign mac_vld_o   = mac_vld_q;
    assign res_vld_o   = res_vld_q;
    assign busy_o      = busy_q;

endmodule

// File: doc/mac_ctrl.md
MAC_CTRL -- requirements
Module: mac_ctrl

Interface
REQ-001 SHALL have parameter WI, default 8, operand width of one MAC lane.
REQ-002 SHALL have parameter N, default 16, number of lanes per MAC chunk.
REQ-003 SHALL have parameter MW, default 26, width of the MAC result (2*WI+$clog2(N)+6).
REQ-004 SHALL have parameter MAC_LAT, default 9, cycles from MAC valid-in to MAC valid-out.
REQ-005 SHALL have parameters AW, default 10, buffer address width; LW, default 8, chunk-count width; ACC_W, default 32, result width.
REQ-006 SHALL have ports, in this order:
  - clk, input, 1, single clock; all logic is rising-edge.
  - rstn, input, 1, asynchronous active-low reset.
  - cmd_vld_i, input, 1, command valid.
  - cmd_rdy_o, output, 1, command ready.
  - cmd_len_i, input, LW, number of N-lane chunks.
  - cmd_wbase_i, input, AW, weight start address.
  - cmd_dbase_i, input, AW, activation start address.
  - buf_rd_o, output, 1, buffer read strobe; data returns 1 cycle later straight onto the MAC inputs.
  - buf_waddr_o, output, AW, weight read address.
  - buf_daddr_o, output, AW, activation read address.
  - mac_vld_o, output, 1, MAC valid-in.
  - mac_vld_i, input, 1, MAC valid-out.
  - mac_acc_i, input, MW, signed MAC result.
  - res_vld_o, output, 1, result valid.
  - res_rdy_i, input, 1, result ready.
  - res_data_o, output, ACC_W, signed dot-product result.
  - res_sat_o, output, 1, result saturated; qualified by res_vld_o.
  - busy_o, output, 1, high whenever the state is not IDLE.

Function
REQ-007 SHALL implement FSM states IDLE, ISSUE, DRAIN and OUT with the following transitions:
  - IDLE to ISSUE on cmd_vld_i & cmd_rdy_o when len>0.
  - IDLE to OUT when len=0.
  - ISSUE to DRAIN after len reads have been issued.
  - DRAIN to OUT when received count equals len.
  - OUT to IDLE on res_vld_o & res_rdy_i.
REQ-008 SHALL drive cmd_rdy_o high only in IDLE, and SHALL register len, wbase and dbase on acceptance.
REQ-009 In ISSUE, SHALL assert buf_rd_o once per cycle with no bubbles, issuing len reads; read k SHALL use addresses wbase+k and dbase+k, wrapping modulo 2^AW.
REQ-010 SHALL drive mac_vld_o as buf_rd_o delayed by exactly one cycle.
REQ-011 SHALL count mac_vld_i pulses only in ISSUE and DRAIN, and SHALL ignore them in IDLE and OUT.
REQ-012 On each counted mac_vld_i, SHALL add sign-extended mac_acc_i into a signed ACC_W accumulator.
REQ-013 Accumulation SHALL saturate to +2^(ACC_W-1)-1 or -2^(ACC_W-1), and SHALL set a sticky sat flag that is cleared on command acceptance.
REQ-014 The accumulator and received count SHALL clear on command acceptance.
REQ-015 In OUT, res_data_o and res_sat_o SHALL hold stable while res_vld_o=1 and res_rdy_i=0.
REQ-016 Latency: for a command accepted at cycle 0 with len=L>0, reads SHALL be issued in cycles 1..L and res_vld_o SHALL first rise at cycle L+MAC_LAT+2.
REQ-017 For len=0, res_vld_o SHALL rise at cycle 1 with res_data_o=0 and res_sat_o=0.
REQ-018 A new command SHALL be accepted no earlier than the cycle after the result handshake.
REQ-019 With res_rdy_i held at 1, the block SHALL need L+MAC_LAT+3 cycles per command.

Reset
REQ-020 While rstn=0, the FSM SHALL go to IDLE immediately, asynchronously.
REQ-021 While rstn=0, all outputs SHALL be 0 except cmd_rdy_o, which SHALL be 1 after reset is released.
REQ-022 Reset asserted mid-command SHALL discard the command.
REQ-023 MAC results still in flight after reset release SHALL be ignored, because the FSM is then in IDLE.

Structure
REQ-024 A shared package mac_pkg SHALL hold WI, N, MW, MAC_LAT and ACC_W, plus the FSM state typedef.
REQ-025 The saturating accumulator (add, clamp, sticky flag) SHALL be a sub-module named mac_sat_acc.
REQ-026 The address counters and FSM SHALL stay in mac_ctrl.

Verification
REQ-027 Single command: len=4, wbase=0x010, dbase=0x200, MAC model returns 100,200,-50,7 -> addresses 0x010..0x013 and 0x200..0x203 in cycles 1-4; res_vld_o at cycle 15; res_data_o=257; res_sat_o=0.
REQ-028 Zero length: len=0 -> no buf_rd_o; res_vld_o at cycle 1; res_data_o=0.
REQ-029 Saturation and wrap: len=3, each result +2^25-1, ACC_W=26 override -> res_data_o=2^25-1; res_sat_o=1. Separately, wbase=0x3FE with len=4 -> weight addresses 0x3FE,0x3FF,0x000,0x001.
REQ-030 Backpressure: res_rdy_i=0 for 5 cycles after res_vld_o -> res_data_o stable; cmd_rdy_o=0 throughout; a new command is accepted the cycle after the handshake.
REQ-031 Reset mid-operation: rstn pulsed low at cycle 3 of a len=8 command -> outputs go to 0 immediately; late mac_vld_i pulses are ignored; the next len=2 command returns only its own sum.
REQ-032 Stray pulse: mac_vld_i with mac_acc_i=55 asserted while in IDLE -> the next command's result excludes 55.
